uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2: number of requesters, legal range 2..8.
REQ-002 The block SHALL have parameter TIMEOUT, default 20'd1000000: idle-lock timeout in CLK cycles (10 ms at 100 MHz), used only with ARB_TIMEOUT_EN.
REQ-003 The block SHALL have port CLK  in  1  system clock; all logic on the rising edge.
REQ-004 The block SHALL have port RST_N  in  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port req_valid  in  NUM_REQ  bit i high: requester i presents a byte.
REQ-006 The block SHALL have port req_data  in  8*NUM_REQ  byte of requester i on [8i+7:8i].
REQ-007 The block SHALL have port req_last  in  NUM_REQ  bit i high: the presented byte ends requester i's packet.
REQ-008 The block SHALL have port req_ack  out  NUM_REQ  one-cycle pulse: byte of requester i accepted.
REQ-009 The block SHALL have port grant  out  NUM_REQ  one-hot current owner, all zero when unowned.
REQ-010 The block SHALL have port tx_send  out  1  one-cycle send strobe to the UART transmitter.
REQ-011 The block SHALL have port tx_data  out  8  byte to transmit.
REQ-012 The block SHALL have port tx_ready  in  1  transmitter idle.
REQ-013 The block SHALL have port busy  out  1  high when state is not IDLE or a packet lock is held.
REQ-014 The block SHALL have port timeout  out  1  one-cycle pulse on forced lock release.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, SETTLE and WAIT_RDY.
REQ-016 IDLE->LOAD SHALL occur when tx_ready=1 and an eligible req_valid bit is high; otherwise the FSM stays in IDLE.
REQ-017 With no lock held, the eligible requester SHALL be picked round-robin: first valid index after rr_ptr, modulo NUM_REQ.
REQ-018 With a lock held, only the lock owner SHALL be eligible; other requests are ignored.
REQ-019 On IDLE->LOAD the block SHALL register the owner's req_data into tx_data, set grant, and set the lock.
REQ-020 In LOAD, tx_send and req_ack[owner] SHALL be high for exactly one cycle; LOAD->SETTLE is unconditional.
REQ-021 Latency SHALL be: request sampled in IDLE at edge N gives tx_send=1 and req_ack=1 during cycle N+1.
REQ-022 SETTLE SHALL last one cycle, ignore tx_ready, and go to WAIT_RDY.
REQ-023 WAIT_RDY SHALL go to IDLE when tx_ready=1.
REQ-024 If the accepted byte had req_last=1, on that transition the block SHALL clear the lock, clear grant and set rr_ptr=owner.
REQ-025 tx_data SHALL stay stable from LOAD until the next LOAD.
REQ-026 Requesters SHALL hold req_valid/req_data/req_last until req_ack; the block samples only in IDLE.
REQ-027 If the owner drops req_valid mid-packet, the lock SHALL be held and the block waits in IDLE.
REQ-028 Simultaneous valid requests SHALL be resolved by REQ-017 only; a requester SHALL never receive two acks for one byte.

Reset
REQ-029 RST_N=0 SHALL immediately force: state IDLE, lock cleared, grant=0, req_ack=0, tx_send=0, tx_data=8'h00, busy=0, timeout=0, and rr_ptr=NUM_REQ-1 so requester 0 has first priority.
REQ-030 Reset mid-transfer SHALL abort the transfer; no ack is issued for the aborted byte.

Configuration
REQ-031 With macro ARB_TIMEOUT_EN defined, a counter SHALL count cycles spent in IDLE with lock held and req_valid[owner]=0, and SHALL clear on any other cycle.
REQ-032 When that counter reaches TIMEOUT-1, the block SHALL clear lock and grant, set rr_ptr=owner, and pulse timeout for one cycle.
REQ-033 Without ARB_TIMEOUT_EN, no counter SHALL exist, the lock SHALL be held indefinitely, and timeout SHALL be tied to 0.

Verification
REQ-034 The bench SHALL cover: req0 byte 8'h41 last=1, tx_ready=1 -> tx_send and req_ack[0] high the cycle after sampling, tx_data=8'h41, grant=01 then 00.
REQ-035 The bench SHALL cover: req0 and req1 valid in the same cycle after reset -> req0 served first, then req1; repeat after both finish -> req0 served first again.
REQ-036 The bench SHALL cover: req0 sends 3-byte packet 02,54,03 while req1 is valid -> all three req0 bytes go out before any req1 byte.
REQ-037 The bench SHALL cover: tx_ready held low 50 cycles in WAIT_RDY -> no tx_send, FSM stays in WAIT_RDY, and leaves it the cycle after tx_ready rises.
REQ-038 The bench SHALL cover: with ARB_TIMEOUT_EN and TIMEOUT=16, the owner drops valid mid-packet -> timeout pulse after 16 idle cycles, then req1 is granted.
REQ-039 The bench SHALL cover: RST_N low during SETTLE -> all outputs 0 at once, and no ack is issued after release.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter feeding one UART transmitter, with per-packet lock.
// Optional idle-lock release timer enabled by defining ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int          NUM_REQ = 2,
  parameter logic [19:0] TIMEOUT = 20'd1000000
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_send,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE,
    WAIT_RDY
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_lock;
  logic            r_last;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_rr_ptr;
  logic [7:0]      r_tx_data;

  logic [IW-1:0]   w_cand;
  logic [IW-1:0]   w_pick;
  logic            w_found;
  logic [IW-1:0]   w_sel;
  logic            w_elig;
  logic            w_start;
  logic            w_release;
  logic            w_expire;
  logic [7:0]      w_data;

  // First valid requester after the round-robin pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (int'(r_rr_ptr) + k >= NUM_REQ)
        w_cand = IW'(int'(r_rr_ptr) + k - NUM_REQ);
      else
        w_cand = IW'(int'(r_rr_ptr) + k);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign w_sel     = r_lock ? r_owner : w_pick;
  assign w_elig    = r_lock ? req_valid[r_owner] : w_found;
  assign w_start   = (r_state == IDLE) && tx_ready && w_elig;
  assign w_release = (r_state == WAIT_RDY) && tx_ready && r_last;
  assign w_data    = req_data[{w_sel, 3'b000} +: 8];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (w_start) w_next = LOAD;
      LOAD:     w_next = SETTLE;
      SETTLE:   w_next = WAIT_RDY;
      WAIT_RDY: if (tx_ready) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= IDLE;
      r_lock    <= 1'b0;
      r_last    <= 1'b0;
      r_owner   <= '0;
      r_rr_ptr  <= IW'(NUM_REQ - 1);
      r_tx_data <= 8'h00;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_lock    <= 1'b1;
        r_owner   <= w_sel;
        r_last    <= req_last[w_sel];
        r_tx_data <= w_data;
      end else if (w_release || w_expire) begin
        r_lock   <= 1'b0;
        r_rr_ptr <= r_owner;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [19:0] r_cnt;
  logic        r_timeout;
  logic        w_idle_wait;

  // Owner holds the lock but has stopped presenting bytes.
  assign w_idle_wait = (r_state == IDLE) && r_lock &&
                       !req_valid[r_owner];
  assign w_expire    = w_idle_wait &&
                       (r_cnt == TIMEOUT - 20'd1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      if (w_idle_wait && !w_expire)
        r_cnt <= r_cnt + 20'd1;
      else
        r_cnt <= '0;
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^TIMEOUT;
  assign w_expire         = 1'b0;
  assign timeout          = 1'b0;
`endif

  assign grant   = r_lock ? (NUM_REQ'(1) << r_owner) : '0;
  assign tx_send = (r_state == LOAD);
  assign req_ack = tx_send ? grant : '0;
  assign tx_data = r_tx_data;
  assign busy    = (r_state != IDLE) || r_lock;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter (two requesters).
// Timeout scenario expectations switch on ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } rb_t;

  typedef struct packed {
    logic [1:0] ack;
    logic [7:0] d;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_ack;
  logic [1:0]  grant;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        timeout;

  rb_t  rq0[$];
  rb_t  rq1[$];
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_arbiter #(
    .NUM_REQ(2),
    .TIMEOUT(20'd16)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ack   (req_ack),
    .grant     (grant),
    .tx_send   (tx_send),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int id, input logic [7:0] d,
                      input logic l, input bit scored);
    logic [1:0] a;
    a = (id == 0) ? 2'b01 : 2'b10;
    if (id == 0) rq0.push_back({d, l});
    else         rq1.push_back({d, l});
    if (scored) sb.push_back({a, d});
  endtask

  // Requesters: present queue head, retire it on ack.
  always @(negedge CLK) begin
    if (req_ack[0] && rq0.size() > 0) rq0.delete(0);
    if (req_ack[1] && rq1.size() > 0) rq1.delete(0);
    req_valid[0]   = rq0.size() > 0;
    req_data[7:0]  = (rq0.size() > 0) ? rq0[0].d : 8'h00;
    req_last[0]    = (rq0.size() > 0) ? rq0[0].l : 1'b0;
    req_valid[1]   = rq1.size() > 0;
    req_data[15:8] = (rq1.size() > 0) ? rq1[0].d : 8'h00;
    req_last[1]    = (rq1.size() > 0) ? rq1[0].l : 1'b0;
  end

  // Output monitor: every send must match the scoreboard head.
  always @(negedge CLK) begin
    exp_t e;
    if (tx_send) begin
      if (sb.size() == 0) begin
        chk("unexpected_send", 32'(tx_data), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("send_data", 32'(tx_data), 32'(e.d));
        chk("send_ack", 32'(req_ack), 32'(e.ack));
        chk("send_grant", 32'(grant), 32'(e.ack));
      end
    end else begin
      chk("ack_without_send", 32'(req_ack), 0);
    end
  end

  task automatic wait_send(input string tag);
    int n = 0;
    @(negedge CLK);
    while (!tx_send && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, 32'(tx_send), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge CLK);
    while ((busy || sb.size() != 0) && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, 32'(busy || sb.size() != 0), 0);
  endtask

  task automatic do_reset();
    @(posedge CLK) #1 RST_N = 1'b0;
    @(negedge CLK);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_send", 32'(tx_send), 0);
    chk("rst_ack", 32'(req_ack), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout", 32'(timeout), 0);
    @(posedge CLK) #1 RST_N = 1'b1;
  endtask

  initial begin
    int cnt;
    int bad;

    // Single byte, exact latency, grant set then cleared.
    do_reset();
    @(posedge CLK) #1;
    push(0, 8'h41, 1'b1, 1'b1);
    @(negedge CLK);
    chk("lat_not_yet", 32'(tx_send), 0);
    @(negedge CLK);
    chk("lat_send", 32'(tx_send), 1);
    chk("lat_ack", 32'(req_ack), 32'h1);
    chk("lat_data", 32'(tx_data), 32'h41);
    chk("lat_grant", 32'(grant), 32'h1);
    wait_idle("single_idle");
    chk("single_grant_clr", 32'(grant), 0);

    // Simultaneous requests after reset, twice.
    do_reset();
    @(posedge CLK) #1;
    push(0, 8'hA0, 1'b1, 1'b1);
    push(1, 8'hB0, 1'b1, 1'b1);
    wait_idle("rr1_idle");
    @(posedge CLK) #1;
    push(0, 8'hA1, 1'b1, 1'b1);
    push(1, 8'hB1, 1'b1, 1'b1);
    wait_idle("rr2_idle");

    // Locked 3-byte packet against a competing requester.
    @(posedge CLK) #1;
    push(0, 8'h02, 1'b0, 1'b1);
    push(0, 8'h54, 1'b0, 1'b1);
    push(0, 8'h03, 1'b1, 1'b1);
    push(1, 8'h77, 1'b1, 1'b1);
    wait_idle("pkt_idle");

    // Transmitter stalls for 50 cycles after a send.
    @(posedge CLK) #1;
    push(0, 8'h5A, 1'b1, 1'b1);
    wait_send("stall_send");
    tx_ready = 1'b0;
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (tx_send) cnt++;
      if (!busy || tx_data !== 8'h5A) bad++;
    end
    chk("stall_no_send", 32'(cnt), 0);
    chk("stall_held", 32'(bad), 0);
    tx_ready = 1'b1;
    @(negedge CLK);
    chk("stall_exit_busy", 32'(busy), 0);
    chk("stall_exit_grant", 32'(grant), 0);

    // Owner drops valid mid-packet while requester 1 waits.
    do_reset();
    @(posedge CLK) #1;
    push(0, 8'h11, 1'b0, 1'b1);
    wait_send("drop_send");
`ifdef ARB_TIMEOUT_EN
    push(1, 8'h22, 1'b1, 1'b1);
    bad = 0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge CLK);
      if (timeout) bad++;
    end
    chk("to_early", 32'(bad), 0);
    @(negedge CLK);
    chk("to_pulse", 32'(timeout), 1);
    chk("to_grant_clr", 32'(grant), 0);
    chk("to_busy_clr", 32'(busy), 0);
    @(negedge CLK);
    chk("to_one_cycle", 32'(timeout), 0);
    chk("to_req1_send", 32'(tx_send), 1);
    wait_idle("to_idle");
`else
    push(1, 8'h22, 1'b1, 1'b0);
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (tx_send) cnt++;
      if (timeout) bad++;
    end
    chk("lock_no_send", 32'(cnt), 0);
    chk("lock_no_timeout", 32'(bad), 0);
    chk("lock_grant", 32'(grant), 32'h1);
    chk("lock_busy", 32'(busy), 1);
    @(posedge CLK) #1;
    push(0, 8'h33, 1'b1, 1'b1);
    sb.push_back({2'b10, 8'h22});
    wait_idle("lock_idle");
`endif

    // Reset asserted while in SETTLE.
    @(posedge CLK) #1;
    push(0, 8'h66, 1'b1, 1'b1);
    wait_send("rst_mid_send");
    @(posedge CLK) #2;
    RST_N = 1'b0;
    #1;
    chk("rstm_send", 32'(tx_send), 0);
    chk("rstm_ack", 32'(req_ack), 0);
    chk("rstm_grant", 32'(grant), 0);
    chk("rstm_data", 32'(tx_data), 0);
    chk("rstm_busy", 32'(busy), 0);
    chk("rstm_timeout", 32'(timeout), 0);
    repeat (2) @(negedge CLK);
    @(posedge CLK) #1 RST_N = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (tx_send || req_ack != 2'b00) cnt++;
    end
    chk("rstm_no_ack", 32'(cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
